// File: rtl/eth_pkg.sv
// rtl/eth_pkg.sv - shared Ethernet frame encodings, constants and field lengths
package eth_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_PREAMBLE  = 3'd1,
        ST_DEST_ADDR = 3'd2,
        ST_SRC_ADDR  = 3'd3,
        ST_ETH_TYPE  = 3'd4,
        ST_PAYLOAD   = 3'd5,
        ST_FCS       = 3'd6,
        ST_DRAIN     = 3'd7
    } eth_state_e;

    localparam logic [7:0]  PREAMBLE_BYTE   = 8'h55;
    localparam logic [7:0]  SFD_BYTE        = 8'hD5;
    localparam logic [7:0]  FCS_PLACEHOLDER = 8'hFF;
    localparam logic [47:0] BROADCAST_ADDR  = 48'hFFFF_FFFF_FFFF;

    localparam logic [2:0] DEST_LEN     = 3'd6;
    localparam logic [2:0] SRC_LEN      = 3'd6;
    localparam logic [2:0] TYPE_LEN     = 3'd2;
    localparam logic [2:0] PAYLOAD_LEN  = 3'd4;
    localparam logic [2:0] PREAMBLE_MAX = 3'd7;

    function automatic logic [2:0] field_len(eth_state_e s);
        case (s)
            ST_DEST_ADDR: return DEST_LEN;
            ST_SRC_ADDR:  return SRC_LEN;
            ST_ETH_TYPE:  return TYPE_LEN;
            ST_PAYLOAD:   return PAYLOAD_LEN;
            default:      return 3'd1;
        endcase
    endfunction

endpackage

// File: rtl/eth_rx_shreg.sv
// rtl/eth_rx_shreg.sv - 48-bit byte shift register with load-enable and clear
module eth_rx_shreg (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clr_i,
    input  logic        en_i,
    input  logic [7:0]  byte_i,
    output logic [47:0] data_o
);

    logic [47:0] data_q;

    // Big-endian fill: earliest byte ends up in the MSBs once the field is complete.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q <= '0;
        end else if (clr_i) begin
            data_q <= '0;
        end else if (en_i) begin
            data_q <= {data_q[39:0], byte_i};
        end
    end

    assign data_o = data_q;

endmodule

// File: rtl/eth_frame_receiver.sv
// rtl/eth_frame_receiver.sv - byte-wide Ethernet frame receiver with good/bad/filtered pulses
// Optional destination filtering is built when ADDR_FILTER_EN is defined.
module eth_frame_receiver
    import eth_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        rx_dv,
    input  logic [7:0]  rx_in,
    input  logic [47:0] mac_addr,
    output logic [47:0] dest_addr,
    output logic [47:0] src_addr,
    output logic [15:0] eth_type,
    output logic [31:0] data_out,
    output logic        frame_valid,
    output logic        frame_err,
    output logic        frame_drop,
    output logic        rx_busy,
    output logic [2:0]  state
);

    eth_state_e  state_q, state_d;
    logic [2:0]  byte_cnt_q, byte_cnt_d;
    logic        cap_clr, dest_en, src_en, tp_en;
    logic        fcs_good, frame_bad, addr_ok;
    logic [47:0] dest_cap, src_cap, tp_cap;
    logic        valid_q, err_q, drop_q, busy_q;
    logic [47:0] dest_q, src_q;
    logic [15:0] type_q;
    logic [31:0] data_q;

    always_comb begin
        state_d    = state_q;
        byte_cnt_d = byte_cnt_q;
        cap_clr    = 1'b0;
        dest_en    = 1'b0;
        src_en     = 1'b0;
        tp_en      = 1'b0;
        fcs_good   = 1'b0;
        frame_bad  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (rx_dv) begin
                    state_d = (rx_in == PREAMBLE_BYTE) ? ST_PREAMBLE : ST_DRAIN;
                end
            end
            ST_PREAMBLE: begin
                if (!rx_dv) begin
                    state_d = ST_IDLE;
                end else if (rx_in == PREAMBLE_BYTE) begin
                    if (byte_cnt_q != PREAMBLE_MAX) byte_cnt_d = byte_cnt_q + 3'd1;
                end else if (rx_in == SFD_BYTE) begin
                    state_d = ST_DEST_ADDR;
                    cap_clr = 1'b1;
                end else begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DEST_ADDR, ST_SRC_ADDR, ST_ETH_TYPE, ST_PAYLOAD: begin
                if (!rx_dv) begin
                    state_d   = ST_IDLE;
                    frame_bad = 1'b1;
                    cap_clr   = 1'b1;
                end else begin
                    dest_en = (state_q == ST_DEST_ADDR);
                    src_en  = (state_q == ST_SRC_ADDR);
                    tp_en   = (state_q == ST_ETH_TYPE) || (state_q == ST_PAYLOAD);
                    if (byte_cnt_q == field_len(state_q) - 3'd1) begin
                        state_d = eth_state_e'(state_q + 3'd1);
                    end else begin
                        byte_cnt_d = byte_cnt_q + 3'd1;
                    end
                end
            end
            ST_FCS: begin
                if (!rx_dv) begin
                    state_d   = ST_IDLE;
                    frame_bad = 1'b1;
                    cap_clr   = 1'b1;
                end else begin
                    state_d   = ST_DRAIN;
                    fcs_good  = (rx_in == FCS_PLACEHOLDER);
                    frame_bad = (rx_in != FCS_PLACEHOLDER);
                end
            end
            ST_DRAIN: begin
                if (!rx_dv) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        // Entering PREAMBLE already counts the byte that caused the move.
        if (state_d != state_q) begin
            byte_cnt_d = (state_d == ST_PREAMBLE) ? 3'd1 : 3'd0;
        end
    end

    eth_rx_shreg u_dest_shreg (
        .clk(clk), .rst_n(rst_n), .clr_i(cap_clr), .en_i(dest_en), .byte_i(rx_in), .data_o(dest_cap)
    );
    eth_rx_shreg u_src_shreg (
        .clk(clk), .rst_n(rst_n), .clr_i(cap_clr), .en_i(src_en), .byte_i(rx_in), .data_o(src_cap)
    );
    // Type and payload share one register: {type[15:0], payload[31:0]} after six bytes.
    eth_rx_shreg u_tp_shreg (
        .clk(clk), .rst_n(rst_n), .clr_i(cap_clr), .en_i(tp_en), .byte_i(rx_in), .data_o(tp_cap)
    );

`ifdef ADDR_FILTER_EN
    assign addr_ok = (dest_cap == mac_addr) || (dest_cap == BROADCAST_ADDR);
`else
    logic unused_mac_addr;
    assign unused_mac_addr = ^mac_addr;
    assign addr_ok = 1'b1;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            byte_cnt_q <= 3'd0;
            busy_q     <= 1'b0;
            valid_q    <= 1'b0;
            err_q      <= 1'b0;
            drop_q     <= 1'b0;
            dest_q     <= '0;
            src_q      <= '0;
            type_q     <= '0;
            data_q     <= '0;
        end else begin
            state_q    <= state_d;
            byte_cnt_q <= byte_cnt_d;
            busy_q     <= (state_d != ST_IDLE);
            valid_q    <= fcs_good && addr_ok;
            err_q      <= frame_bad;
            drop_q     <= fcs_good && !addr_ok;
            if (fcs_good && addr_ok) begin
                dest_q <= dest_cap;
                src_q  <= src_cap;
                type_q <= tp_cap[47:32];
                data_q <= tp_cap[31:0];
            end
        end
    end

    assign dest_addr   = dest_q;
    assign src_addr    = src_q;
    assign eth_type    = type_q;
    assign data_out    = data_q;
    assign frame_valid = valid_q;
    assign frame_err   = err_q;
    assign frame_drop  = drop_q;
    assign rx_busy     = busy_q;
    assign state       = state_q;

endmodule

// File: tb/tb_eth_frame_receiver.sv
// tb/tb_eth_frame_receiver.sv - randomized self-checking bench for eth_frame_receiver
module tb_eth_frame_receiver;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        rx_dv = 1'b0;
    logic [7:0]  rx_in = 8'h00;
    logic [47:0] mac_addr = 48'h0A1B2C3D4E5F;
    logic [47:0] dest_addr, src_addr;
    logic [15:0] eth_type;
    logic [31:0] data_out;
    logic        frame_valid, frame_err, frame_drop, rx_busy;
    logic [2:0]  state;

    eth_frame_receiver dut (
        .clk(clk), .rst_n(rst_n), .rx_dv(rx_dv), .rx_in(rx_in), .mac_addr(mac_addr),
        .dest_addr(dest_addr), .src_addr(src_addr), .eth_type(eth_type), .data_out(data_out),
        .frame_valid(frame_valid), .frame_err(frame_err), .frame_drop(frame_drop),
        .rx_busy(rx_busy), .state(state)
    );

    always #5 clk = ~clk;

    int compared = 0;
    int mismatched = 0;
    int cyc = 0;
    int n_valid = 0, n_err = 0, n_drop = 0;
    int valid_cyc = 0;
    logic [47:0] exp_dest = '0, exp_src = '0;
    logic [15:0] exp_type = '0;
    logic [31:0] exp_data = '0;

    // Outcome from frame rules: 0 accepted, 1 error, 2 filtered.
    function automatic int expect_outcome(input logic [47:0] d, input logic [7:0] fcs, input int abort_at);
        if (abort_at >= 0) return 1;
        if (fcs != 8'hFF) return 1;
`ifdef ADDR_FILTER_EN
        if (d != mac_addr && d != 48'hFFFF_FFFF_FFFF) return 2;
`endif
        return 0;
    endfunction

    task automatic step(input logic dv, input logic [7:0] b);
        @(negedge clk);
        rx_dv = dv;
        rx_in = b;
        @(posedge clk);
        #1;
        cyc++;
        if (frame_valid) begin n_valid++; valid_cyc = cyc; end
        if (frame_err) n_err++;
        if (frame_drop) n_drop++;
        compared++;
        if (int'(frame_valid) + int'(frame_err) + int'(frame_drop) > 1) begin
            mismatched++;
            $display("FAIL exclusive_pulses cyc=%0d got v/e/d=%b%b%b want at most one", cyc, frame_valid, frame_err, frame_drop);
        end
    endtask

    task automatic check_fields(input string name);
        compared++;
        if ({dest_addr, src_addr, eth_type, data_out} !== {exp_dest, exp_src, exp_type, exp_data}) begin
            mismatched++;
            $display("FAIL %s_fields got %h/%h/%h/%h want %h/%h/%h/%h", name, dest_addr, src_addr, eth_type,
                     data_out, exp_dest, exp_src, exp_type, exp_data);
        end
    endtask

    task automatic run_frame(input string name, input int pre_len, input logic [47:0] d, input logic [47:0] s,
                             input logic [15:0] t, input logic [31:0] p, input logic [7:0] fcs, input int abort_at);
        logic [7:0] body[$];
        logic [2:0] exp_vec;
        logic [2:0] exp_state;
        int exp;
        int first_cyc = 0;
        exp = expect_outcome(d, fcs, abort_at);
        exp_vec = (exp == 0) ? 3'b100 : (exp == 1) ? 3'b010 : 3'b001;
        for (int i = 5; i >= 0; i--) body.push_back(d[i*8 +: 8]);
        for (int i = 5; i >= 0; i--) body.push_back(s[i*8 +: 8]);
        for (int i = 1; i >= 0; i--) body.push_back(t[i*8 +: 8]);
        for (int i = 3; i >= 0; i--) body.push_back(p[i*8 +: 8]);
        body.push_back(fcs);
        n_valid = 0; n_err = 0; n_drop = 0;
        for (int i = 0; i < pre_len; i++) begin
            step(1'b1, 8'h55);
            if (i == 0) first_cyc = cyc;
        end
        step(1'b1, 8'hD5);
        for (int i = 0; i < 19; i++) begin
            if (i == abort_at) begin
                step(1'b0, 8'($urandom));
                break;
            end
            step(1'b1, body[i]);
        end
        compared++;
        if ({frame_valid, frame_err, frame_drop} !== exp_vec) begin
            mismatched++;
            $display("FAIL %s_pulse got v/e/d=%b%b%b want %b", name, frame_valid, frame_err, frame_drop, exp_vec);
        end
        exp_state = (abort_at >= 0) ? 3'd0 : 3'd7;
        compared++;
        if (state !== exp_state || rx_busy !== (exp_state != 3'd0)) begin
            mismatched++;
            $display("FAIL %s_state got %0d busy=%b want %0d", name, state, rx_busy, exp_state);
        end
        if (exp == 0) begin
            exp_dest = d; exp_src = s; exp_type = t; exp_data = p;
        end
        check_fields(name);
        if (exp == 0 && pre_len == 7) begin
            compared++;
            if (valid_cyc - first_cyc != 26) begin
                mismatched++;
                $display("FAIL %s_latency got %0d edges want 26", name, valid_cyc - first_cyc);
            end
        end
        step(1'b0, 8'($urandom));
        compared++;
        if ({n_valid, n_err, n_drop} !== {int'(exp == 0), int'(exp == 1), int'(exp == 2)} || state !== 3'd0) begin
            mismatched++;
            $display("FAIL %s_counts got v/e/d=%0d/%0d/%0d state=%0d want %0d/%0d/%0d state=0", name,
                     n_valid, n_err, n_drop, state, int'(exp == 0), int'(exp == 1), int'(exp == 2));
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        compared++;
        if (state !== 3'd0 || rx_busy !== 1'b0 || {frame_valid, frame_err, frame_drop} !== 3'b000) begin
            mismatched++;
            $display("FAIL reset_ctrl got state=%0d busy=%b pulses=%b want 0/0/000", state, rx_busy,
                     {frame_valid, frame_err, frame_drop});
        end
        check_fields("reset");
        rst_n = 1'b1;
        step(1'b0, 8'h00);
        compared++;
        if (state !== 3'd0 || rx_busy !== 1'b0) begin
            mismatched++;
            $display("FAIL reset_idle got state=%0d busy=%b want 0/0", state, rx_busy);
        end
    endtask

    task automatic test_good_frame();
        run_frame("good", 7, 48'h0A1B2C3D4E5F, 48'h112233445566, 16'h0800, 32'hDEADBEEF, 8'hFF, -1);
    endtask

    task automatic test_bad_fcs();
        run_frame("bad_fcs", 7, 48'h0A1B2C3D4E5F, 48'h665544332211, 16'h86DD, 32'h01234567, 8'h00, -1);
    endtask

    task automatic test_abort();
        run_frame("abort_src3", 7, 48'h0A1B2C3D4E5F, 48'h112233445566, 16'h0800, 32'hCAFEF00D, 8'hFF, 9);
        run_frame("after_abort", 7, 48'h0A1B2C3D4E5F, 48'hA0A1A2A3A4A5, 16'h0806, 32'h13572468, 8'hFF, -1);
    endtask

    task automatic test_short_preamble();
        run_frame("short_pre", 2, 48'h0A1B2C3D4E5F, 48'h0C0D0E0F1011, 16'h0800, 32'h89ABCDEF, 8'hFF, -1);
    endtask

    task automatic test_garbage();
        n_valid = 0; n_err = 0; n_drop = 0;
        step(1'b1, 8'h12);
        for (int i = 0; i < 4; i++) step(1'b1, 8'($urandom));
        compared++;
        if (state !== 3'd7 || rx_busy !== 1'b1) begin
            mismatched++;
            $display("FAIL garbage_drain got state=%0d busy=%b want 7/1", state, rx_busy);
        end
        step(1'b0, 8'h00);
        compared++;
        if (state !== 3'd0 || {n_valid, n_err, n_drop} !== {32'd0, 32'd0, 32'd0}) begin
            mismatched++;
            $display("FAIL garbage_idle got state=%0d v/e/d=%0d/%0d/%0d want 0 and no pulses", state, n_valid, n_err, n_drop);
        end
        check_fields("garbage");
    endtask

    task automatic test_filter();
        run_frame("filter_miss", 7, 48'h0A1B2C3D4E60, 48'h223344556677, 16'h0800, 32'h55AA55AA, 8'hFF, -1);
        run_frame("broadcast", 7, 48'hFFFFFFFFFFFF, 48'h223344556677, 16'h0806, 32'hAA55AA55, 8'hFF, -1);
    endtask

    task automatic test_back_to_back();
        run_frame("b2b_a", 1, 48'h0A1B2C3D4E5F, 48'h010203040506, 16'h0800, 32'h11111111, 8'hFF, -1);
        run_frame("b2b_b", 3, 48'h0A1B2C3D4E60, 48'h060504030201, 16'h0800, 32'h22222222, 8'hFF, -1);
        run_frame("b2b_c", 7, 48'hFFFFFFFFFFFF, 48'h0708090A0B0C, 16'h0842, 32'h33333333, 8'hFF, -1);
    endtask

    task automatic test_random();
        for (int n = 0; n < 30; n++) begin
            logic [47:0] d;
            logic [7:0]  fcs;
            int          sel, ab;
            sel = $urandom_range(0, 2);
            d = (sel == 0) ? mac_addr : (sel == 1) ? 48'hFFFF_FFFF_FFFF : {$urandom, $urandom} ;
            fcs = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 254)) : 8'hFF;
            ab = ($urandom_range(0, 4) == 0) ? $urandom_range(0, 18) : -1;
            run_frame("rand", $urandom_range(1, 9), d, {$urandom, $urandom}, 16'($urandom), $urandom, fcs, ab);
        end
    endtask

    task automatic test_mid_reset();
        step(1'b1, 8'h55);
        step(1'b1, 8'hD5);
        for (int i = 0; i < 5; i++) step(1'b1, 8'($urandom));
        #2;
        rst_n = 1'b0;
        #1;
        exp_dest = '0; exp_src = '0; exp_type = '0; exp_data = '0;
        compared++;
        if (state !== 3'd0 || rx_busy !== 1'b0 || {frame_valid, frame_err, frame_drop} !== 3'b000) begin
            mismatched++;
            $display("FAIL mid_reset_ctrl got state=%0d busy=%b pulses=%b want 0/0/000", state, rx_busy,
                     {frame_valid, frame_err, frame_drop});
        end
        check_fields("mid_reset");
        @(negedge clk);
        rx_dv = 1'b0;
        rst_n = 1'b1;
        run_frame("post_reset", 7, 48'h0A1B2C3D4E5F, 48'h112233445566, 16'h0800, 32'hDEADBEEF, 8'hFF, -1);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        test_reset();
        test_good_frame();
        test_bad_fcs();
        test_abort();
        test_short_preamble();
        test_garbage();
        test_filter();
        test_back_to_back();
        test_random();
        test_mid_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
